// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares the core memory port between fetch and LSU.
// One transaction in flight; D-side wins unless fetch has starved.
module core_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        i_kill,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           state_q;
  state_t           state_d;
  logic             own_d_q;
  logic             drop_q;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;

  logic arb;
  logic resp;
  logic i_elig;
  logic cnt_max;
  logic d_win;
  logic i_win;

  always_comb begin
    resp    = (state_q == RESP) && mem_rvalid;
    arb     = (state_q == IDLE) || resp;
    i_elig  = i_req && !i_kill;
    cnt_max = (cnt_q == LIMIT);
    d_win   = d_req && !(cnt_max && i_elig);
    i_win   = i_elig && !d_win;
  end

  assign d_gnt = arb && d_win;
  assign i_gnt = arb && i_win;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_gnt || d_gnt) state_d = REQ;
      REQ:     if (mem_gnt) state_d = RESP;
      RESP:    if (mem_rvalid) state_d = (i_gnt || d_gnt) ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_req   = (state_q == REQ);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

  // a killed fetch still completes on the bus; only its return is hidden
  assign i_rvalid = resp && !own_d_q && !drop_q;
  assign d_rvalid = resp && own_d_q;
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      own_d_q <= 1'b0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (d_gnt) begin
        own_d_q <= 1'b1;
        we_q    <= d_we;
        addr_q  <= d_addr;
        be_q    <= d_be;
        wdata_q <= d_wdata;
      end else if (i_gnt) begin
        own_d_q <= 1'b0;
        we_q    <= 1'b0;
        addr_q  <= i_addr;
        be_q    <= 4'hF;
        wdata_q <= '0;
      end
      if (d_gnt || i_gnt) begin
        drop_q <= 1'b0;
      end else if (i_kill && !own_d_q && state_q != IDLE) begin
        drop_q <= 1'b1;
      end
      if (arb) begin
        if (i_gnt || !i_req) begin
          cnt_q <= '0;
        end else if (d_gnt && !cnt_max) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: directed scenarios plus random traffic, scored
// against a transaction-level model of the arbiter and a memory model.
`timescale 1ns/1ps
module tb_core_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_kill = 1'b0;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  core_mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill),
    .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          d;
    bit          killed;
    bit          chk;
    logic [31:0] data;
  } ent_t;

  ent_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] bus_mem [logic [31:0]];

  bit          m_busy = 0, m_req = 0, m_own_d = 0;
  int          m_streak = 0;
  logic        m_we = 0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [3:0]  m_be = '0;
  bit          resp_due = 0, saw_i = 0, saw_d = 0, log_en = 0;
  string       glog = "";
  int          last_ignt_cyc = -100, last_irv_cyc = -200, n_irv = 0;
  logic [31:0] last_irdata = '0;

  int          gfix = 0, rfix = 1, gw = 0, rv_cnt = 0;
  logic [31:0] rv_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h t=%0t",
                  nm, act, exp, $time);
  endtask

  task automatic chk_str(input string nm, input string act,
                         input string exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=%s required=%s", nm, act, exp);
  endtask

  function automatic logic [31:0] mem_rd(input bit bus,
                                         input logic [31:0] a);
    if (bus) return bus_mem.exists(a) ? bus_mem[a] : a ^ 32'hC0DE_0000;
    return ref_mem.exists(a) ? ref_mem[a] : a ^ 32'hC0DE_0000;
  endfunction

  task automatic mem_wr(input bit bus, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] w);
    logic [31:0] v;
    v = mem_rd(bus, a);
    for (int b = 0; b < 4; b++)
      if (be[b]) v[8*b +: 8] = w[8*b +: 8];
    if (bus) bus_mem[a] = v;
    else ref_mem[a] = v;
  endtask

  function automatic logic [31:0] rnd_addr();
    return 32'h1000 + ($urandom_range(0, 15) << 2);
  endfunction

  // reference model: one transaction at a time, D first unless fetch starved
  always @(negedge clk) begin
    bit   resp_now, arb, i_ok, e_i, e_d;
    ent_t e;
    #3;
    if (!rst_n) begin
      m_busy = 0; m_req = 0; m_streak = 0;
      sb.delete();
      resp_due = 0; saw_i = 0; saw_d = 0;
    end else begin
      resp_now = m_busy && !m_req && mem_rvalid;
      resp_due = resp_now;
      arb  = !m_busy || resp_now;
      i_ok = i_req && !i_kill;
      e_d  = arb && d_req && !(m_streak == LIMIT && i_ok);
      e_i  = arb && i_ok && !e_d;
      chk("i_gnt", 64'(i_gnt), 64'(e_i));
      chk("d_gnt", 64'(d_gnt), 64'(e_d));
      chk("mem_req", 64'(mem_req), 64'(m_req));
      if (m_req) begin
        chk("mem_fields", 64'({mem_we, mem_be, mem_addr}),
            64'({m_we, m_be, m_addr}));
        if (m_we) chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
      end
      saw_i = i_gnt;
      saw_d = d_gnt;
      if (i_gnt) last_ignt_cyc = cyc;
      if (log_en && d_gnt) glog = {glog, "D"};
      if (log_en && i_gnt) glog = {glog, "I"};
      if (m_busy && !resp_now && !m_own_d && i_kill && sb.size() > 0)
        sb[sb.size()-1].killed = 1;
      if (resp_now) m_busy = 0;
      if (m_req && mem_gnt) m_req = 0;
      if (e_d) begin
        e.d = 1; e.killed = 0; e.chk = !d_we;
        e.data = d_we ? 32'h0 : mem_rd(0, d_addr);
        if (d_we) mem_wr(0, d_addr, d_be, d_wdata);
        m_we = d_we; m_addr = d_addr; m_be = d_be; m_wdata = d_wdata;
        m_own_d = 1;
      end else if (e_i) begin
        e.d = 0; e.killed = 0; e.chk = 1;
        e.data = mem_rd(0, i_addr);
        m_we = 0; m_addr = i_addr; m_be = 4'hF; m_wdata = '0;
        m_own_d = 0;
      end
      if (e_d || e_i) begin
        sb.push_back(e);
        m_busy = 1; m_req = 1;
      end
      if (e_i || (arb && !i_req)) m_streak = 0;
      else if (e_d && m_streak < LIMIT) m_streak++;
    end
  end

  // response monitor
  always @(negedge clk) begin
    ent_t e;
    #4;
    if (rst_n && (i_rvalid || d_rvalid || resp_due)) begin
      if (i_rvalid) begin
        last_irv_cyc = cyc; last_irdata = i_rdata; n_irv++;
      end
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL rvalid_unexpected: i_rvalid=%b d_rvalid=%b required=0 t=%0t",
                 i_rvalid, d_rvalid, $time);
      end else begin
        e = sb.pop_front();
        chk("i_rvalid", 64'(i_rvalid), 64'(!e.d && !e.killed));
        chk("d_rvalid", 64'(d_rvalid), 64'(e.d));
        if (!e.d && !e.killed) chk("i_rdata", 64'(i_rdata), 64'(e.data));
        if (e.d && e.chk) chk("d_rdata", 64'(d_rdata), 64'(e.data));
      end
    end
  end

  task automatic mem_drive();
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom;
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin mem_rvalid = 1; mem_rdata = rv_data; end
    end else if (mem_req) begin
      if (gw == 0) begin
        mem_gnt = 1;
        if (mem_we) begin
          mem_wr(1, mem_addr, mem_be, mem_wdata);
          rv_data = $urandom;
        end else begin
          rv_data = mem_rd(1, mem_addr);
        end
        rv_cnt = rfix > 0 ? rfix : int'($urandom_range(1, 3));
        gw = gfix >= 0 ? gfix : int'($urandom_range(0, 3));
      end else begin
        gw--;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (saw_i) i_req = 0;
    if (saw_d) d_req = 0;
    i_kill = 0;
    mem_drive();
  endtask

  task automatic wait_gnt(input bit d_side, input int max);
    int k;
    k = 0;
    #4;
    while (!(d_side ? saw_d : saw_i) && k < max) begin
      tick(); #4; k++;
    end
    if (k >= max) begin
      n_checks++;
      $display("FAIL gnt_timeout: side_d=%b no grant within %0d cycles",
               d_side, max);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((i_req || d_req || m_busy || sb.size() > 0) && k < 60) begin
      tick(); k++;
    end
    if (k >= 60) begin
      n_checks++;
      $display("FAIL drain_timeout: busy=%b queued=%0d required idle",
               m_busy, sb.size());
    end
    tick();
  endtask

  initial begin
    int kc, r0, nreq, nrv;
    tick(); tick();
    rst_n = 1;
    #4;
    chk("reset_ctl", 64'({i_gnt, i_rvalid, d_gnt, d_rvalid,
                          mem_req, mem_we, mem_be}), 64'h0);
    chk("reset_mem", 64'({mem_addr, mem_wdata}), 64'h0);
    chk("reset_rdata", 64'({i_rdata, d_rdata}), 64'h0);

    // single fetch, minimum latency
    ref_mem[32'h100] = 32'h13; bus_mem[32'h100] = 32'h13;
    tick(); i_req = 1; i_addr = 32'h100;
    wait_gnt(0, 5);
    repeat (3) tick();
    chk("t1_latency", 64'(last_irv_cyc - last_ignt_cyc), 64'd2);
    chk("t1_rdata", 64'(last_irdata), 64'h13);

    // contested: D,D,D,D,I repeating
    repeat (3) tick();
    glog = ""; log_en = 1;
    for (int k = 0; k < 24; k++) begin
      tick();
      i_req = 1; i_addr = 32'h104;
      d_req = 1; d_we = 0; d_addr = 32'h2000; d_be = 4'hF;
    end
    log_en = 0;
    drain();
    if (glog.len() >= 10) chk_str("t2_pattern", glog.substr(0, 9), "DDDDIDDDDI");
    else chk_str("t2_pattern", glog, "DDDDIDDDDI");

    // store with delayed mem_gnt, then read back
    gfix = 3; gw = 3; rfix = -1;
    tick(); d_req = 1; d_we = 1; d_addr = 32'h1010;
    d_be = 4'b0011; d_wdata = 32'hDEADBEEF;
    wait_gnt(1, 5);
    gfix = 0;
    nreq = 0; nrv = 0;
    repeat (10) begin
      tick(); #4;
      nreq += int'(mem_req); nrv += int'(d_rvalid);
    end
    chk("t3_req_cycles", 64'(nreq), 64'd4);
    chk("t3_rvalid_pulses", 64'(nrv), 64'd1);
    tick(); d_req = 1; d_we = 0; d_addr = 32'h1010; d_be = 4'hF;
    drain();

    // kill an outstanding fetch in RESP
    gfix = 0; gw = 0; rfix = 3;
    r0 = n_irv;
    tick(); i_req = 1; i_addr = 32'h180;
    wait_gnt(0, 5);
    tick();
    tick(); i_kill = 1; i_req = 1; i_addr = 32'h200; kc = cyc;
    tick();
    wait_gnt(0, 5);
    chk("t4_regrant_cycle", 64'(cyc - kc), 64'd2);
    drain();
    chk("t4_irvalid_count", 64'(n_irv - r0), 64'd1);

    // kill together with request in IDLE
    rfix = 1;
    for (int k = 0; k < 3; k++) begin
      tick(); i_req = 1; i_kill = 1; i_addr = 32'h300;
      #4;
      chk("t5_no_grant", 64'({i_gnt, d_gnt, mem_req}), 64'h0);
    end
    tick();
    wait_gnt(0, 3);
    drain();

    // reset while in REQ, then a stray response
    gfix = 5; gw = 5;
    tick(); d_req = 1; d_we = 0; d_addr = 32'h1020; d_be = 4'hF;
    wait_gnt(1, 5);
    tick();
    tick(); rst_n = 0; mem_gnt = 0; mem_rvalid = 0; i_req = 0; d_req = 0;
    rv_cnt = 0; gfix = 0; gw = 0;
    tick(); rst_n = 1;
    #4;
    chk("t6_after_reset", 64'({i_gnt, d_gnt, i_rvalid, d_rvalid,
                               mem_req, mem_we, mem_be}), 64'h0);
    chk("t6_after_reset_addr", 64'(mem_addr), 64'h0);
    tick();
    tick(); mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
    #4;
    chk("t6_stray_rvalid", 64'({i_rvalid, d_rvalid}), 64'h0);
    tick();

    // random traffic
    gfix = -1; rfix = -1;
    for (int k = 0; k < 4000; k++) begin
      tick();
      if (!i_req && $urandom_range(0, 99) < 35) begin
        i_req = 1; i_addr = rnd_addr();
      end
      if ($urandom_range(0, 99) < 6) begin
        i_kill = 1;
        if (i_req) i_addr = rnd_addr();
      end
      if (!d_req && $urandom_range(0, 99) < 35) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1));
        d_addr = rnd_addr(); d_be = 4'($urandom); d_wdata = $urandom;
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
